// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight writers in EXE/MEM/WB slots and
// freezes IF/ID when a decoded source cannot be served by forwarding or the RF.
module hazard_scoreboard #(
  parameter int ADDR_W        = 5,
  parameter int CNT_W         = 16,
  parameter bit RF_WRITE_THRU = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic [ADDR_W-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic              forward_EN,
  input  logic              flush,
  input  logic              stall_count_clr,
  output logic              hazard_detected,
  output logic [ADDR_W-1:0] dest_EXE,
  output logic [ADDR_W-1:0] dest_MEM,
  output logic [ADDR_W-1:0] dest_WB,
  output logic              WB_EN_EXE,
  output logic              WB_EN_MEM,
  output logic              WB_EN_WB,
  output logic              MEM_R_EN_EXE,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Register 0 is hardwired, so a match on it never creates a dependency.
  function automatic logic match(input logic en, input logic [ADDR_W-1:0] dest,
                                 input logic [ADDR_W-1:0] src);
    return en && (dest == src) && (src != '0);
  endfunction

  function automatic logic src_hazard(input logic [ADDR_W-1:0] src);
    logic m_exe, m_mem, m_wb;
    m_exe = match(WB_EN_EXE, dest_EXE, src);
    m_mem = match(WB_EN_MEM, dest_MEM, src);
    m_wb  = match(WB_EN_WB, dest_WB, src);
    if (forward_EN)
      return m_exe && MEM_R_EN_EXE;
    return m_exe || m_mem || (!RF_WRITE_THRU && m_wb);
  endfunction

  always_comb begin
    hazard_detected = 1'b0;
    if (id_valid && !flush)
      hazard_detected = src_hazard(id_src1) || (id_two_src && src_hazard(id_src2));
  end

  // Slots shift every edge; a stalled, flushed or invalid ID enters EXE as a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_EXE     <= '0;
      dest_MEM     <= '0;
      dest_WB      <= '0;
      WB_EN_EXE    <= 1'b0;
      WB_EN_MEM    <= 1'b0;
      WB_EN_WB     <= 1'b0;
      MEM_R_EN_EXE <= 1'b0;
    end else begin
      dest_WB   <= dest_MEM;
      WB_EN_WB  <= WB_EN_MEM;
      dest_MEM  <= dest_EXE;
      WB_EN_MEM <= WB_EN_EXE;
      if (id_valid && !hazard_detected && !flush) begin
        dest_EXE     <= id_dest;
        WB_EN_EXE    <= id_wb_en && (id_dest != '0);
        MEM_R_EN_EXE <= id_mem_read;
      end else begin
        dest_EXE     <= '0;
        WB_EN_EXE    <= 1'b0;
        MEM_R_EN_EXE <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (stall_count_clr)
      stall_count <= '0;
    else if (hazard_detected && (stall_count != CNT_MAX))
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard; a distance-based model of
// the in-flight instruction list predicts each cycle, a monitor checks the DUT.
module tb_hazard_scoreboard;

  localparam int ADDR_W        = 5;
  localparam int CNT_W         = 4;
  localparam bit RF_WRITE_THRU = 1'b1;
  localparam int CNT_MAX       = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_valid = 1'b0;
  logic [ADDR_W-1:0] id_src1 = '0;
  logic [ADDR_W-1:0] id_src2 = '0;
  logic              id_two_src = 1'b0;
  logic [ADDR_W-1:0] id_dest = '0;
  logic              id_wb_en = 1'b0;
  logic              id_mem_read = 1'b0;
  logic              forward_EN = 1'b0;
  logic              flush = 1'b0;
  logic              stall_count_clr = 1'b0;
  logic              hazard_detected;
  logic [ADDR_W-1:0] dest_EXE, dest_MEM, dest_WB;
  logic              WB_EN_EXE, WB_EN_MEM, WB_EN_WB, MEM_R_EN_EXE;
  logic [CNT_W-1:0]  stall_count;

  hazard_scoreboard #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RF_WRITE_THRU(RF_WRITE_THRU)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .forward_EN(forward_EN), .flush(flush),
    .stall_count_clr(stall_count_clr), .hazard_detected(hazard_detected),
    .dest_EXE(dest_EXE), .dest_MEM(dest_MEM), .dest_WB(dest_WB),
    .WB_EN_EXE(WB_EN_EXE), .WB_EN_MEM(WB_EN_MEM), .WB_EN_WB(WB_EN_WB),
    .MEM_R_EN_EXE(MEM_R_EN_EXE), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              wb;
    logic              mr;
    logic [ADDR_W-1:0] dest;
  } instr_t;

  typedef struct packed {
    logic              hz;
    logic [ADDR_W-1:0] de, dm, dw;
    logic              we, wm, ww, mre;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t   exp_q[$];
  instr_t flight[$];   // flight[0] is the instruction one ahead of ID
  int     model_cnt;
  int     errors = 0;
  int     checks = 0;

  // A writer blocks a source if forwarding cannot reach it at its distance from ID.
  function automatic logic writer_blocks(int age, instr_t w, logic [ADDR_W-1:0] s, logic fwd);
    if (!w.wb || w.dest != s || s == '0) return 1'b0;
    if (fwd) return (age == 0) && w.mr;
    return age <= (RF_WRITE_THRU ? 1 : 2);
  endfunction

  function automatic logic model_hazard(logic v, logic [ADDR_W-1:0] s1, logic [ADDR_W-1:0] s2,
                                        logic two, logic fwd, logic fl);
    logic h = 1'b0;
    if (!v || fl) return 1'b0;
    for (int i = 0; i < flight.size(); i++) begin
      if (writer_blocks(i, flight[i], s1, fwd)) h = 1'b1;
      if (two && writer_blocks(i, flight[i], s2, fwd)) h = 1'b1;
    end
    return h;
  endfunction

  function automatic void model_reset();
    flight.delete();
    repeat (3) flight.push_back('0);
    model_cnt = 0;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compare("hazard_detected", 32'(hazard_detected), 32'(e.hz));
    compare("slots {dE,dM,dW,weE,weM,weW,mrE}",
            32'({dest_EXE, dest_MEM, dest_WB, WB_EN_EXE, WB_EN_MEM, WB_EN_WB, MEM_R_EN_EXE}),
            32'({e.de, e.dm, e.dw, e.we, e.wm, e.ww, e.mre}));
    compare("stall_count", 32'(stall_count), 32'(e.cnt));
  endtask

  // One cycle: drive at negedge, predict, then advance the model past the next posedge.
  task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2,
                               input logic two, input logic [ADDR_W-1:0] d, input logic wb,
                               input logic mr, input logic fwd, input logic fl, input logic clr,
                               input logic rs, output logic h);
    exp_t   e;
    instr_t ne;
    @(negedge clk);
    rst = rs; id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_dest = d; id_wb_en = wb; id_mem_read = mr; forward_EN = fwd; flush = fl;
    stall_count_clr = clr;
    #1;
    if (rs) model_reset();
    h = model_hazard(v, s1, s2, two, fwd, fl);
    e = '{hz: h, de: flight[0].dest, dm: flight[1].dest, dw: flight[2].dest,
          we: flight[0].wb, wm: flight[1].wb, ww: flight[2].wb, mre: flight[0].mr,
          cnt: CNT_W'(model_cnt)};
    exp_q.push_back(e);
    if (!rs) begin
      ne = (v && !h && !fl) ? '{wb: wb && (d != '0), mr: mr, dest: d} : '0;
      flight.push_front(ne);
      void'(flight.pop_back());
      if (clr) model_cnt = 0;
      else if (h && model_cnt < CNT_MAX) model_cnt++;
    end
  endtask

  task automatic idle(input int n, input logic clr);
    logic h;
    repeat (n) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, clr, 1'b0, h);
  endtask

  // Hold the instruction in ID until the model says it has issued.
  task automatic issue(input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2, input logic two,
                       input logic [ADDR_W-1:0] d, input logic wb, input logic mr, input logic fwd);
    logic h;
    int   n = 0;
    do begin
      applyStimulus(1'b1, s1, s2, two, d, wb, mr, fwd, 1'b0, 1'b0, 1'b0, h);
      n++;
    end while (h && n < 10);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    logic h;
    model_reset();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, h);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, h);

    $display("[TB] load-use with forwarding");
    issue(5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1);
    issue(5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b0);

    $display("[TB] ALU dependency without forwarding");
    issue(5'd1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    issue(5'd5, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);

    $display("[TB] register 0 writer and reader");
    issue(5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
    issue(5'd0, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);

    $display("[TB] flush with load-use");
    issue(5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, h);
    idle(3, 1'b0);

    $display("[TB] stall counter saturation");
    idle(1, 1'b1);
    repeat (9) begin
      issue(5'd1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
      issue(5'd5, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    end
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(9, 0) < 8), ADDR_W'($urandom_range(7, 0)),
                    ADDR_W'($urandom_range(7, 0)), 1'($urandom), ADDR_W'($urandom_range(7, 0)),
                    ($urandom_range(3, 0) != 0), 1'($urandom), 1'($urandom),
                    ($urandom_range(9, 0) == 0), ($urandom_range(29, 0) == 0), 1'b0, h);
    end

    $display("[TB] reset with full slots");
    issue(5'd0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b1);
    issue(5'd0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1);
    issue(5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 5'd3, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, h);
    idle(2, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
